// File: rtl/agc_ctr_pkg.sv
// ---------------------------------------------------------------------------
// agc_ctr_pkg
// Shared definitions for the AGC counter-cycle arbiter.
//   ctr_state_t   : arbiter FSM state (IDLE = no counter cycle, CYCLE = INKL)
//   DEF_NCELLS    : default number of involuntary counter cells
//   DEF_BASE_ADDR : default erasable address of counter cell 0
//   DEF_AW        : default address width
// ---------------------------------------------------------------------------
package agc_ctr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CYCLE = 1'b1
  } ctr_state_t;

  localparam int DEF_NCELLS    = 20;
  localparam int DEF_BASE_ADDR = 12'o0024;
  localparam int DEF_AW        = 12;

endpackage

// File: rtl/ctr_prio_enc.sv
// ---------------------------------------------------------------------------
// ctr_prio_enc
// Combinational lowest-index priority encoder used to pick which pending
// counter cell is served next.
// Ports:
//   i_req   [N-1:0]  : request vector, bit i = cell i pending
//   o_valid          : at least one request present
//   o_idx   [IW-1:0] : index of the lowest set request bit (0 if none)
//   o_grant [N-1:0]  : one-hot mask of the winning bit (0 if none)
// ---------------------------------------------------------------------------
module ctr_prio_enc #(
  parameter int N  = 20,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_valid,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_grant
);

  // The one-hot grant isolates the lowest set bit with the two's-complement
  // trick. The index scan walks from the top down so that the last hit, which
  // is the lowest index, is the one that remains.
  always_comb begin
    o_valid = |i_req;
    o_grant = i_req & (~i_req + N'(1));
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/agc_counter_priority.sv
// ---------------------------------------------------------------------------
// agc_counter_priority
// Counter-cycle arbiter for the AGC involuntary counters. Collects plus and
// minus increment requests per cell, cancels opposing requests, and at each
// memory-cycle boundary decides whether the next memory cycle is stolen to
// update the lowest-index pending cell.
// Ports:
//   CLOCK               : system clock
//   SIM_RST_n           : synchronous active-low reset
//   PREQ    [NCELLS-1:0]: plus request per cell, sampled when STBE=1
//   MREQ    [NCELLS-1:0]: minus request per cell, sampled when STBE=1
//   STBE                : request sample strobe
//   MCT_END             : last cycle of a memory cycle
//   GINH                : inhibit new counter cycles (looked at on MCT_END)
//   INKL                : counter cycle in progress
//   CTR_ADDR [AW-1:0]   : address of the served cell, 0 when idle
//   PINC / MINC         : direction of the served update
//   CTR_ACK             : one-cycle pulse after a counter cycle completes
//   CTR_PEND            : at least one cell pending
// ---------------------------------------------------------------------------
module agc_counter_priority
  import agc_ctr_pkg::*;
#(
  parameter int NCELLS    = DEF_NCELLS,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int AW        = DEF_AW
) (
  input  logic              CLOCK,
  input  logic              SIM_RST_n,
  input  logic [NCELLS-1:0] PREQ,
  input  logic [NCELLS-1:0] MREQ,
  input  logic              STBE,
  input  logic              MCT_END,
  input  logic              GINH,
  output logic              INKL,
  output logic [AW-1:0]     CTR_ADDR,
  output logic              PINC,
  output logic              MINC,
  output logic              CTR_ACK,
  output logic              CTR_PEND
);

  localparam int IW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  // The last cell address has to fit in the address bus.
  if (NCELLS + BASE_ADDR > (1 << AW)) begin : g_widthCheck
    $error("agc_counter_priority: NCELLS + BASE_ADDR exceeds 2**AW");
  end

  ctr_state_t        r_state;
  ctr_state_t        w_nextState;
  logic [NCELLS-1:0] r_pp;
  logic [NCELLS-1:0] r_pm;
  logic [AW-1:0]     r_addr;
  logic              r_pinc;
  logic              r_minc;
  logic              r_ack;
  logic              r_pend;

  logic              w_valid;
  logic [IW-1:0]     w_idx;
  logic [NCELLS-1:0] w_grant;
  logic [NCELLS-1:0] w_mask;
  logic [AW-1:0]     w_addrNext;
  logic              w_pincNext;
  logic              w_mincNext;
  logic              w_ackNext;
  logic [NCELLS-1:0] w_np;
  logic [NCELLS-1:0] w_nm;
  logic [NCELLS-1:0] w_cancel;
  logic [NCELLS-1:0] w_newP;
  logic [NCELLS-1:0] w_newM;

  // Arbitration looks only at the registered pending bits, so a request
  // strobed on the same edge as MCT_END waits for the next decision.
  ctr_prio_enc #(
    .N  (NCELLS),
    .IW (IW)
  ) u_prioEnc (
    .i_req   (r_pp | r_pm),
    .o_valid (w_valid),
    .o_idx   (w_idx),
    .o_grant (w_grant)
  );

  // Next-state and output decode. Nothing moves except on MCT_END; at that
  // boundary a running cycle always acknowledges, and a new (or back-to-back)
  // cycle starts whenever something is pending and GINH is low. The winner's
  // direction bits are captured here and its pending bits are cleared through
  // w_mask on the same edge.
  always_comb begin
    w_nextState = r_state;
    w_mask      = '0;
    w_addrNext  = r_addr;
    w_pincNext  = r_pinc;
    w_mincNext  = r_minc;
    w_ackNext   = 1'b0;
    if (MCT_END) begin
      w_ackNext = (r_state == CYCLE);
      if (w_valid && !GINH) begin
        w_nextState = CYCLE;
        w_mask      = w_grant;
        w_addrNext  = AW'(BASE_ADDR) + AW'(w_idx);
        w_pincNext  = |(r_pp & w_grant);
        w_mincNext  = |(r_pm & w_grant);
      end else begin
        w_nextState = IDLE;
        w_addrNext  = '0;
        w_pincNext  = 1'b0;
        w_mincNext  = 1'b0;
      end
    end
  end

  // Pending update: drop the granted cell first, then merge the strobed
  // requests, and cancel opposing bits last. Because the grant clear comes
  // first, a new request for the cell being granted survives, and an opposite
  // request arriving after a grant cannot undo the committed increment.
  assign w_np     = (r_pp & ~w_mask) | (PREQ & {NCELLS{STBE}});
  assign w_nm     = (r_pm & ~w_mask) | (MREQ & {NCELLS{STBE}});
  assign w_cancel = w_np & w_nm;
  assign w_newP   = w_np & ~w_cancel;
  assign w_newM   = w_nm & ~w_cancel;

  // FSM state register.
  always_ff @(posedge CLOCK) begin
    if (!SIM_RST_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pending bits and registered outputs. Reset wins over everything, so a
  // reset during a counter cycle drops it without an acknowledge.
  always_ff @(posedge CLOCK) begin
    if (!SIM_RST_n) begin
      r_pp   <= '0;
      r_pm   <= '0;
      r_addr <= '0;
      r_pinc <= 1'b0;
      r_minc <= 1'b0;
      r_ack  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_pp   <= w_newP;
      r_pm   <= w_newM;
      r_addr <= w_addrNext;
      r_pinc <= w_pincNext;
      r_minc <= w_mincNext;
      r_ack  <= w_ackNext;
      r_pend <= |(w_newP | w_newM);
    end
  end

  assign INKL     = (r_state == CYCLE);
  assign CTR_ADDR = r_addr;
  assign PINC     = r_pinc;
  assign MINC     = r_minc;
  assign CTR_ACK  = r_ack;
  assign CTR_PEND = r_pend;

endmodule

// File: doc/agc_counter_priority.md
# agc_counter_priority

Counter-cycle arbiter for the AGC involuntary-counter cells. It accumulates plus and minus increment requests from NCELLS counter cells and cancels opposing requests per cell. At each memory-cycle boundary it decides whether the next memory cycle is stolen for a counter update. When it steals a cycle, it drives INKL, the counter address and the increment direction to the sequence generator and write/adder datapath for exactly one memory cycle.

## Interface
Parameters:
- NCELLS, 20, number of counter cells; cell i maps to erasable address BASE_ADDR+i
- BASE_ADDR, 12'o0024, address of cell 0
- AW, 12, address width

Ports:
- CLOCK  in  1  system clock
- SIM_RST_n  in  1  synchronous, active-low reset
- PREQ  in  NCELLS  plus-increment request per cell, sampled only when STBE=1
- MREQ  in  NCELLS  minus-increment request per cell, sampled only when STBE=1
- STBE  in  1  request-sample strobe, single cycle
- MCT_END  in  1  single-cycle pulse marking the last cycle of a memory cycle
- GINH  in  1  inhibit new counter cycles; sampled at MCT_END only
- INKL  out  1  counter cycle in progress
- CTR_ADDR  out  AW  address of the cell being served; 0 when INKL=0
- PINC  out  1  served cell is incremented; valid while INKL=1
- MINC  out  1  served cell is decremented; valid while INKL=1
- CTR_ACK  out  1  single-cycle pulse when a counter cycle completes
- CTR_PEND  out  1  at least one cell pending

## Operation
- Pending state is two bits per cell: pp[i] and pm[i].
- When STBE=1, each cell merges its inputs:
  - np = pp | PREQ
  - nm = pm | MREQ
  - if np&nm, both bits clear (opposite requests cancel)
  - else the bits take np/nm
- A request already pending in the same direction is absorbed. Requests are not counted twice.
- Arbitration is fixed priority: the lowest-index cell with pp|pm set wins.
- FSM states:
  - IDLE: INKL=0.
  - CYCLE: INKL=1.
- Transitions on an edge with MCT_END=1:
  - From IDLE: if any cell is pending and GINH=0, go to CYCLE. Load CTR_ADDR=BASE_ADDR+winner and PINC=pp[w], MINC=pm[w]. Clear the winner's pending bits on the same edge (grant-time clear).
  - From CYCLE: pulse CTR_ACK. Then, if a cell is pending and GINH=0, stay in CYCLE and load the next winner (back-to-back counter cycles). Otherwise go to IDLE, and INKL, CTR_ADDR, PINC and MINC return to 0.
- MCT_END=0: no state change. GINH rising mid-cycle does not abort a CYCLE in progress.
- Interaction between STBE and a grant on the same edge:
  - The pending update is (pending & ~grant_mask) merged with the new requests, cancellation applied last.
  - A new request to the cell being granted is therefore retained for a later cycle.
  - An in-flight increment is committed: later opposite requests do not cancel it.
- Width rule: BASE_ADDR+i is computed in AW bits. NCELLS+BASE_ADDR must not exceed 2^AW. This is elaboration-checked.

## Timing
- Reset takes effect on the next CLOCK edge with SIM_RST_n=0. All pending bits clear, FSM goes to IDLE, and INKL=PINC=MINC=CTR_ACK=CTR_PEND=0, CTR_ADDR=0.
- Reset during CYCLE drops INKL on that edge with no CTR_ACK.
- Request latency:
  - A STBE edge makes the request visible to CTR_PEND and arbitration on the following cycle.
  - A request sampled on the same edge as MCT_END misses that decision.
  - Grant occurs at the next MCT_END.
- Outputs:
  - INKL, CTR_ADDR, PINC and MINC are registered and change only on MCT_END edges or reset.
  - INKL stays high for exactly one memory cycle per served request, and continuously across back-to-back grants.
  - CTR_ACK is high for the single cycle after the MCT_END edge that ends a counter cycle.
- CTR_PEND is registered: OR of all pending bits after each update.

## Structure
- Package agc_ctr_pkg holds:
  - FSM enum ctr_state_t {IDLE, CYCLE}
  - default NCELLS and BASE_ADDR constants
- Sub-module ctr_prio_enc is a parameterized lowest-index priority encoder. It outputs a valid flag, the index, and a one-hot grant mask. It is combinational, and the winner is registered in agc_counter_priority.

## Test plan
- Reset mid-cycle:
  - Stimulus: PREQ[3] strobed, MCT_END, so INKL=1 and CTR_ADDR=12'o0027; then SIM_RST_n=0 for one edge.
  - Required: INKL=0, CTR_ADDR=0, CTR_PEND=0, no CTR_ACK.
- Priority:
  - Stimulus: PREQ[5] and MREQ[2] strobed together; four MCT_END pulses.
  - Required: grants go to cell 2 (MINC=1, addr 12'o0026) and then cell 5 (PINC=1, addr 12'o0031) back-to-back. CTR_ACK pulses twice, then INKL falls.
- Cancellation:
  - Stimulus: PREQ[0] strobed, then MREQ[0] strobed before MCT_END.
  - Required: CTR_PEND=0 and no INKL at MCT_END.
  - Repeat with PREQ[0] and MREQ[0] in the same strobe: same result.
- Inhibit:
  - Stimulus: PREQ[7] pending, GINH=1 at two MCT_END pulses, then GINH=0.
  - Required: INKL stays 0 until the third MCT_END, then addr 12'o0033 with PINC=1.
- Grant collision:
  - Stimulus: PREQ[1] pending; STBE with PREQ[1] on the same edge as the granting MCT_END.
  - Required: cell 1 is served twice across two consecutive memory cycles, giving two CTR_ACK pulses.
- Committed increment:
  - Stimulus: during CYCLE serving PINC on cell 4, strobe MREQ[4].
  - Required: current cycle completes with PINC=1. The next cycle serves cell 4 with MINC=1.
